// File: rtl/seq_gen_if.sv
// seq_gen_if: start handshake and serial output bundle for seq_pattern_gen (idle_gap only with SEQ_GEN_GAP_EN)
interface seq_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
`ifdef SEQ_GEN_GAP_EN
  , parameter int GAP_W = 3
`endif
);
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0] idle_gap;
`endif
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic             done;
  modport master (
`ifdef SEQ_GEN_GAP_EN
    output idle_gap,
`endif
    output start_valid, pattern, repeat_cnt,
    input  start_ready, seq_out, seq_valid, busy, done
  );
  modport slave (
`ifdef SEQ_GEN_GAP_EN
    input  idle_gap,
`endif
    input  start_valid, pattern, repeat_cnt,
    output start_ready, seq_out, seq_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern transmitter with repeat count; SEQ_GEN_GAP_EN adds inter-repeat idle gaps
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
`ifdef SEQ_GEN_GAP_EN
  , parameter int GAP_W = 3
`endif
) (
  input logic      clk,
  input logic      reset,
  seq_gen_if.slave bus
);
  localparam int BW = $clog2(PAT_W);
`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [2:0] {IDLE = 3'b001, SHIFT = 3'b010, GAP = 3'b100} state_e;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE = 2'b01, SHIFT = 2'b10} state_e;
`endif
  state_e state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, sh_q, sh_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic done_q, done_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      rep_q <= '0;
      done_q <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_len_q <= '0;
      gap_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      rep_q <= rep_d;
      done_q <= done_d;
`ifdef SEQ_GEN_GAP_EN
      gap_len_q <= gap_len_d;
      gap_q <= gap_d;
`endif
    end
  end
  // sh_q is kept zero outside SHIFT so seq_out needs no gating
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    sh_d = sh_q;
    idx_d = idx_q;
    rep_d = rep_q;
    done_d = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_len_d = gap_len_q;
    gap_d = gap_q;
`endif
    if (state_q == IDLE) begin
      if (bus.start_valid) begin
        done_d = bus.repeat_cnt == '0;
        if (bus.repeat_cnt != '0) begin
          state_d = SHIFT;
          pat_d = bus.pattern;
          sh_d = bus.pattern;
          idx_d = BW'(PAT_W - 1);
          rep_d = bus.repeat_cnt - 1'b1;
`ifdef SEQ_GEN_GAP_EN
          gap_len_d = bus.idle_gap;
`endif
        end
      end
    end else if (state_q == SHIFT) begin
      sh_d = sh_q << 1;
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) begin
        idx_d = BW'(PAT_W - 1);
        if (rep_q == '0) begin
          state_d = IDLE;
          done_d = 1'b1;
          sh_d = '0;
        end else begin
          rep_d = rep_q - 1'b1;
          sh_d = pat_q;
`ifdef SEQ_GEN_GAP_EN
          if (gap_len_q != '0) begin
            state_d = GAP;
            sh_d = '0;
            gap_d = gap_len_q;
          end
`endif
        end
      end
    end
`ifdef SEQ_GEN_GAP_EN
    else if (state_q == GAP) begin
      gap_d = gap_q - 1'b1;
      state_d = gap_q == GAP_W'(1) ? SHIFT : GAP;
      sh_d = gap_q == GAP_W'(1) ? pat_q : '0;
    end
`endif
  end
  assign bus.start_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.seq_valid = state_q == SHIFT;
  assign bus.seq_out = sh_q[PAT_W-1];
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed and random jobs checked cycle by cycle against an expected bit-stream queue
module tb_seq_pattern_gen;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_W = 3;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
`ifdef SEQ_GEN_GAP_EN
  seq_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();
  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`else
  seq_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif
  always #5 clk = ~clk;
  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  // {start_ready, busy, seq_valid, seq_out, done}
  function automatic logic [4:0] sample();
    return {bus.start_ready, bus.busy, bus.seq_valid, bus.seq_out, bus.done};
  endfunction
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got rdy/busy/vld/out/done=%b want %b", tag, obs, exp);
  endtask
  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk(tag, sample(), 5'b10000);
    end
  endtask
  // Called at a negedge with the DUT idle; the request is accepted at the next rising edge.
  task automatic run_job(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] cnt, input int gap,
                         input bit noise, input int abort_at);
    logic [1:0] q[$];
    int ng = gap;
`ifndef SEQ_GEN_GAP_EN
    ng = 0;
`endif
    for (int r = 0; r < int'(cnt); r++) begin
      if (r > 0) for (int g = 0; g < ng; g++) q.push_back(2'b00);
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back({1'b1, pat[b]});
    end
    bus.pattern = pat;
    bus.repeat_cnt = cnt;
`ifdef SEQ_GEN_GAP_EN
    bus.idle_gap = GAP_W'(gap);
`endif
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = noise;
    foreach (q[k]) begin
      if (noise) begin
        bus.pattern = PAT_W'($urandom);
        bus.repeat_cnt = CNT_W'($urandom);
      end
      chk($sformatf("job %h x%0d cyc%0d", pat, cnt, k), sample(), {2'b01, q[k], 1'b0});
      if (abort_at > 0 && k + 1 == abort_at) begin
        bus.start_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    chk($sformatf("done %h x%0d", pat, cnt), sample(), 5'b10001);
  endtask
  initial begin
    bus.start_valid = 1'b0;
    bus.pattern = '0;
    bus.repeat_cnt = '0;
`ifdef SEQ_GEN_GAP_EN
    bus.idle_gap = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset", sample(), 5'b10000);
    reset = 1'b0;
    idle(1, "post_reset");
    run_job(4'b1011, 4'd1, 0, 1'b0, 0);
    idle(2, "after_single");
    run_job(4'b1010, 4'd0, 0, 1'b0, 0);
    idle(2, "after_zero");
    run_job(4'b1011, 4'd2, 0, 1'b1, 0);
    run_job(4'b0110, 4'd1, 0, 1'b0, 0);
    idle(1, "after_b2b");
    run_job(4'b1001, 4'd15, 0, 1'b0, 0);
    idle(1, "after_max");
    run_job(4'b1101, 4'd3, 0, 1'b0, 5);
    #2 reset = 1'b1;
    #1 chk("async_reset", sample(), 5'b10000);
    @(negedge clk);
    chk("reset_held", sample(), 5'b10000);
    reset = 1'b0;
    idle(3, "no_done_after_abort");
    run_job(4'b1101, 4'd1, 0, 1'b0, 0);
`ifdef SEQ_GEN_GAP_EN
    run_job(4'b1011, 4'd2, 3, 1'b0, 0);
    run_job(4'b1100, 4'd3, 0, 1'b0, 0);
    idle(1, "after_gap");
`endif
    repeat (20) begin
      run_job(PAT_W'($urandom), CNT_W'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) idle(1, "rand_idle");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
